// File: rtl/alu_seq16_pkg.sv
// alu_seq16_pkg
//  Shared definitions for the 16-bit multi-pass controller that sequences the
//  CPU's 8-bit combinational ALU: opcode encodings, FSM state encoding and the
//  default ALU datapath width.
package alu_seq16_pkg;

    localparam int BYTE_W_DEF = 8;

    // Opcodes as seen on ALU_Code; 3'b100 has no ALU meaning and is rejected.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SHR = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_ILL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq16.sv
// alu_seq16
//  Performs 16-bit ADD/SUB/SHR/AND/OR/NOT/XOR by driving an external 8-bit
//  combinational ALU over a low-byte pass, a high-byte pass and, for
//  ADD/SUB/SHR, a fix-up pass that folds in the cross-byte carry, borrow or
//  shifted bit. The ALU has no carry-in, so carries are derived here.
//  Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op, req_a, req_b  opcode and 16-bit operands
//   resp_valid/resp_ready response handshake (response held until accepted)
//   resp_data             16-bit result
//   resp_carry            ADD carry-out / SUB borrow-out
//   resp_err              illegal opcode (resp_data = 0)
//   alu_code/alu_a/alu_b  drive the external ALU
//   alu_out               ALU result, same cycle
//  Optional build macro ALU_SEQ_FLAGS_EN adds resp_zero and resp_neg.
module alu_seq16
    import alu_seq16_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int OP_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [2*BYTE_W-1:0]   req_a,
    input  logic [2*BYTE_W-1:0]   req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [2*BYTE_W-1:0]   resp_data,
    output logic                  resp_carry,
    output logic                  resp_err,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                  resp_zero,
    output logic                  resp_neg,
`endif
    output logic [OP_W-1:0]       alu_code,
    output logic [BYTE_W-1:0]     alu_a,
    output logic [BYTE_W-1:0]     alu_b,
    input  logic [BYTE_W-1:0]     alu_out
);

    state_t                state_r, state_s;
    logic [OP_W-1:0]       op_r, op_s;
    logic [2*BYTE_W-1:0]   a_r, a_s, b_r, b_s;
    logic [BYTE_W-1:0]     res_lo_r, res_lo_s, res_hi_r, res_hi_s;
    logic                  c_lo_r, c_lo_s, c_hi_r, c_hi_s;
    logic                  req_ready_s, resp_valid_s, resp_carry_s, resp_err_s;
    logic [2*BYTE_W-1:0]   resp_data_s;
    logic [OP_W-1:0]       alu_code_s;
    logic [BYTE_W-1:0]     alu_a_s, alu_b_s;

    // Per-byte carry/borrow: an unsigned add wrapped iff the sum is below an
    // addend; a subtract borrows iff the minuend is below the subtrahend.
    function automatic logic byte_carry(input logic [OP_W-1:0] op,
                                        input logic [BYTE_W-1:0] res,
                                        input logic [BYTE_W-1:0] a,
                                        input logic [BYTE_W-1:0] b);
        case (op)
            ALU_ADD: byte_carry = (res < a);
            ALU_SUB: byte_carry = (a < b);
            default: byte_carry = 1'b0;
        endcase
    endfunction

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        a_s          = a_r;
        b_s          = b_r;
        res_lo_s     = res_lo_r;
        res_hi_s     = res_hi_r;
        c_lo_s       = c_lo_r;
        c_hi_s       = c_hi_r;
        resp_valid_s = resp_valid;
        resp_data_s  = resp_data;
        resp_carry_s = resp_carry;
        resp_err_s   = resp_err;
        alu_code_s   = {OP_W{1'b0}};
        alu_a_s      = {BYTE_W{1'b0}};
        alu_b_s      = {BYTE_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    op_s = req_op;
                    a_s  = req_a;
                    b_s  = req_b;
                    if (req_op == ALU_ILL) begin
                        state_s      = S_DONE;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                        resp_carry_s = 1'b0;
                        resp_data_s  = {(2*BYTE_W){1'b0}};
                    end else begin
                        // ALU ports are registered, so load them for the LO pass now.
                        state_s    = S_LO;
                        alu_code_s = req_op;
                        alu_a_s    = req_a[BYTE_W-1:0];
                        alu_b_s    = req_b[BYTE_W-1:0];
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LO: begin
                res_lo_s   = alu_out;
                c_lo_s     = byte_carry(op_r, alu_out, a_r[BYTE_W-1:0], b_r[BYTE_W-1:0]);
                state_s    = S_HI;
                alu_code_s = op_r;
                alu_a_s    = a_r[2*BYTE_W-1:BYTE_W];
                alu_b_s    = b_r[2*BYTE_W-1:BYTE_W];
            end
            S_HI: begin
                res_hi_s = alu_out;
                c_hi_s   = byte_carry(op_r, alu_out, a_r[2*BYTE_W-1:BYTE_W], b_r[2*BYTE_W-1:BYTE_W]);
                case (op_r)
                    ALU_ADD, ALU_SUB: begin
                        // Fix-up adds/subtracts the low-byte carry into the high byte.
                        state_s    = S_FIX;
                        alu_code_s = op_r;
                        alu_a_s    = alu_out;
                        alu_b_s    = {{(BYTE_W-1){1'b0}}, c_lo_r};
                    end
                    ALU_SHR: begin
                        // Fix-up ORs bit 8 of A into bit 7 of the low byte.
                        state_s    = S_FIX;
                        alu_code_s = ALU_OR;
                        alu_a_s    = res_lo_r;
                        alu_b_s    = {a_r[BYTE_W], {(BYTE_W-1){1'b0}}};
                    end
                    default: begin
                        state_s      = S_DONE;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b0;
                        resp_carry_s = 1'b0;
                        resp_data_s  = {alu_out, res_lo_r};
                    end
                endcase
            end
            S_FIX: begin
                state_s      = S_DONE;
                resp_valid_s = 1'b1;
                resp_err_s   = 1'b0;
                case (op_r)
                    ALU_ADD: begin
                        res_hi_s     = alu_out;
                        resp_data_s  = {alu_out, res_lo_r};
                        resp_carry_s = c_hi_r | ((&res_hi_r) & c_lo_r);
                    end
                    ALU_SUB: begin
                        res_hi_s     = alu_out;
                        resp_data_s  = {alu_out, res_lo_r};
                        resp_carry_s = c_hi_r | ((~|res_hi_r) & c_lo_r);
                    end
                    ALU_SHR: begin
                        res_lo_s     = alu_out;
                        resp_data_s  = {res_hi_r, alu_out};
                        resp_carry_s = 1'b0;
                    end
                    default: begin
                        resp_data_s  = {res_hi_r, res_lo_r};
                        resp_carry_s = 1'b0;
                    end
                endcase
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_s      = S_IDLE;
                    resp_valid_s = 1'b0;
                    resp_err_s   = 1'b0;
                    resp_carry_s = 1'b0;
                    resp_data_s  = {(2*BYTE_W){1'b0}};
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        req_ready_s = (state_s == S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r       <= {OP_W{1'b0}};
            a_r        <= {(2*BYTE_W){1'b0}};
            b_r        <= {(2*BYTE_W){1'b0}};
            res_lo_r   <= {BYTE_W{1'b0}};
            res_hi_r   <= {BYTE_W{1'b0}};
            c_lo_r     <= 1'b0;
            c_hi_r     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= {(2*BYTE_W){1'b0}};
            resp_carry <= 1'b0;
            resp_err   <= 1'b0;
            alu_code   <= {OP_W{1'b0}};
            alu_a      <= {BYTE_W{1'b0}};
            alu_b      <= {BYTE_W{1'b0}};
        end else begin
            op_r       <= op_s;
            a_r        <= a_s;
            b_r        <= b_s;
            res_lo_r   <= res_lo_s;
            res_hi_r   <= res_hi_s;
            c_lo_r     <= c_lo_s;
            c_hi_r     <= c_hi_s;
            req_ready  <= req_ready_s;
            resp_valid <= resp_valid_s;
            resp_data  <= resp_data_s;
            resp_carry <= resp_carry_s;
            resp_err   <= resp_err_s;
            alu_code   <= alu_code_s;
            alu_a      <= alu_a_s;
            alu_b      <= alu_b_s;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Result flags track resp_data, which only changes on DONE entry/exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_zero <= 1'b0;
            resp_neg  <= 1'b0;
        end else begin
            resp_zero <= resp_valid_s && (resp_data_s == {(2*BYTE_W){1'b0}});
            resp_neg  <= resp_valid_s && resp_data_s[2*BYTE_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16
//  Directed bench for alu_seq16 with a behavioural 8-bit ALU beside it.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_carry;
    logic        resp_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic        resp_zero;
    logic        resp_neg;
`endif
    logic [2:0]  alu_code;
    logic [7:0]  alu_a, alu_b, alu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_err   (resp_err),
`ifdef ALU_SEQ_FLAGS_EN
        .resp_zero  (resp_zero),
        .resp_neg   (resp_neg),
`endif
        .alu_code   (alu_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    // The CPU's 8-bit combinational ALU.
    always_comb begin
        alu_out = 8'h00;
        case (alu_code)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a >> 1;
            3'b011:  alu_out = alu_a & alu_b;
            3'b101:  alu_out = alu_a | alu_b;
            3'b110:  alu_out = ~alu_a;
            3'b111:  alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        carry;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    // Issue one request, measure latency and check the response, then ack it.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " data"},  {16'd0, resp_data}, {16'd0, v.data});
        chk({tag, " carry"}, {31'd0, resp_carry}, {31'd0, v.carry});
        chk({tag, " err"},   {31'd0, resp_err}, {31'd0, v.err});
`ifdef ALU_SEQ_FLAGS_EN
        chk({tag, " zero"}, {31'd0, resp_zero}, {31'd0, (v.data == 16'h0000)});
        chk({tag, " neg"},  {31'd0, resp_neg},  {31'd0, v.data[15]});
`endif
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, " ack valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " ack ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 4};
        vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4};
        vecs[2]  = '{3'b001, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 4};
        vecs[3]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 4};
        vecs[4]  = '{3'b010, 16'h0101, 16'h5555, 16'h0080, 1'b0, 1'b0, 4};
        vecs[5]  = '{3'b011, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 3};
        vecs[6]  = '{3'b110, 16'h1234, 16'hAAAA, 16'hEDCB, 1'b0, 1'b0, 3};
        vecs[7]  = '{3'b101, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 3};
        vecs[8]  = '{3'b111, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b0, 1'b0, 3};
        vecs[9]  = '{3'b000, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 4};
        vecs[10] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 4};
        vecs[11] = '{3'b001, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 4};
        vecs[12] = '{3'b100, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1};
        vecs[13] = '{3'b010, 16'hFFFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 4};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_data",  {16'd0, resp_data},  32'd0);
        chk("rst resp_carry", {31'd0, resp_carry}, 32'd0);
        chk("rst resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst alu ports",  {8'd0, 5'd0, alu_code, alu_a, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Illegal op held in DONE: outputs must stay put while resp_ready is low.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b100;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("hold%0d err", i),   {31'd0, resp_err},   32'd1);
            chk($sformatf("hold%0d data", i),  {16'd0, resp_data},  32'd0);
            chk($sformatf("hold%0d ready", i), {31'd0, req_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("hold release", {31'd0, resp_valid}, 32'd0);

        // Reset asserted while an ADD is in its HI pass.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort valid", {31'd0, resp_valid}, 32'd0);
        chk("abort ready", {31'd0, req_ready},  32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort no resp", {31'd0, resp_valid}, 32'd0);
        v = '{3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 4};
        run_vec(v, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
